// File: rtl/bit_sel_ctrl.sv
// Sequencer for the e/index bit selector: fetch a vector pair, load it, shift until
// the selector has collected sel_number bits, retrying with fresh vectors on shortfall.
module bit_sel_ctrl #(
    parameter int VEC_LEN   = 450,
    parameter int N_LO      = 128,
    parameter int N_HI      = 256,
    parameter int MAX_RETRY = 3,
    parameter int CW        = 9
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req,
    input  logic          mode,
    output logic          src_req,
    input  logic          src_valid,
    output logic          sel_start,
    output logic          sel_en,
    output logic [CW-1:0] sel_number,
    input  logic          sel_done,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [1:0]    retry_cnt
);

    localparam logic [CW-1:0] VEC_LEN_C = CW'(VEC_LEN);
    localparam logic [CW-1:0] N_LO_C    = CW'(N_LO);
    localparam logic [CW-1:0] N_HI_C    = CW'(N_HI);
    localparam logic [1:0]    MAX_R_C   = 2'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] shift_cnt;
    logic          budget_out;

    assign budget_out = (shift_cnt == VEC_LEN_C);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sel_number <= N_LO_C;
            retry_cnt  <= '0;
            shift_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                sel_number <= mode ? N_HI_C : N_LO_C;
                retry_cnt  <= '0;
            end
            // sel_en already excludes a full budget, so the counter saturates at VEC_LEN
            if (state_q == LOAD)
                shift_cnt <= '0;
            else if (sel_en)
                shift_cnt <= shift_cnt + 1'b1;
            if (state_q == SHIFT && !sel_done && budget_out && retry_cnt < MAX_R_C)
                retry_cnt <= retry_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_req   = 1'b0;
        sel_start = 1'b0;
        sel_en    = 1'b0;
        done      = 1'b0;
        fail      = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE:  if (req) state_d = FETCH;
            FETCH: begin
                src_req = 1'b1;
                if (src_valid) state_d = LOAD;
            end
            LOAD: begin
                sel_start = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                sel_en = !sel_done && !budget_out;
                // a completed selection wins over an exhausted budget
                if (sel_done)
                    state_d = DONE;
                else if (budget_out)
                    state_d = (retry_cnt < MAX_R_C) ? FETCH : ERR;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                done    = 1'b1;
                fail    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bit_sel_ctrl.sv
// Scoreboard bench for bit_sel_ctrl with a behavioural selector and upstream source.
module tb_bit_sel_ctrl;

    localparam int VL = 450;

    logic       clk = 0;
    logic       resetn, req, mode, src_req, src_valid, sel_start, sel_en, sel_done;
    logic [8:0] sel_number;
    logic       busy, done, fail;
    logic [1:0] retry_cnt;

    bit_sel_ctrl dut (
        .clk(clk), .resetn(resetn), .req(req), .mode(mode), .src_req(src_req),
        .src_valid(src_valid), .sel_start(sel_start), .sel_en(sel_en),
        .sel_number(sel_number), .sel_done(sel_done), .busy(busy), .done(done),
        .fail(fail), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fail;
        logic [1:0] retry;
        int         lat;
        int         num;
        int         start;
        int         en;
        int         st;
        int         en_base;
        int         st_base;
    } exp_t;

    exp_t         sb[$];
    logic [VL-1:0] cur_vecs[4];
    int           cur_delay[4];
    int           cur_base = 0;
    int           checks = 0, errors = 0;

    // Environment: selector consumes the index vector MSB first; source honours a per-attempt delay
    int           cyc = 0, en_cnt = 0, st_cnt = 0, sel_cnt = 0, sel_pos = 0, fw = 0;
    logic [VL-1:0] sel_vec = '0;
    int           idx;
    assign idx = (st_cnt - cur_base > 3) ? 3 : st_cnt - cur_base;
    assign sel_done = (sel_cnt >= int'(sel_number));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        fw  <= src_req ? fw + 1 : 0;
        if (sel_en) en_cnt <= en_cnt + 1;
        if (sel_start) begin
            sel_vec <= cur_vecs[idx];
            sel_pos <= 0;
            sel_cnt <= 0;
            st_cnt  <= st_cnt + 1;
        end else if (sel_en && sel_pos < VL) begin
            sel_cnt <= sel_cnt + int'(sel_vec[VL-1-sel_pos]);
            sel_pos <= sel_pos + 1;
        end
    end

    always @(negedge clk) src_valid = src_req && (fw >= cur_delay[idx]);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop on done plus per-cycle protocol properties
    logic       prev_busy = 0;
    logic [8:0] prev_num  = 0;
    always @(negedge clk) begin
        if (resetn) begin
            if (sel_start || sel_en) chk("start_en_exclusive", int'(sel_start && sel_en), 0);
            if (busy && prev_busy) chk("sel_number_stable", int'(sel_number), int'(prev_num));
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("fail", int'(fail), int'(e.fail));
                    chk("retry_cnt", int'(retry_cnt), int'(e.retry));
                    chk("latency", cyc - e.start + 1, e.lat);
                    chk("sel_number", int'(sel_number), e.num);
                    chk("sel_en_cycles", en_cnt - e.en_base, e.en);
                    chk("sel_start_pulses", st_cnt - e.st_base, e.st);
                end
            end
        end
        prev_busy = busy;
        prev_num  = sel_number;
    end

    // Reference: position (1-based, MSB first) of the n-th one, 0 if the vector is short
    function automatic int nth_one(input logic [VL-1:0] v, input int n);
        int c = 0;
        for (int i = 0; i < VL; i++) begin
            c += int'(v[VL-1-i]);
            if (c == n) return i + 1;
        end
        return 0;
    endfunction

    function automatic exp_t model(input logic m);
        exp_t e;
        int   n = m ? 256 : 128;
        e.num = n; e.lat = 1; e.en = 0; e.st = 0; e.fail = 1; e.retry = 3;
        for (int k = 0; k < 4; k++) begin
            int p = nth_one(cur_vecs[k], n);
            e.st++;
            e.lat += cur_delay[k] + 2;
            if (p != 0) begin
                e.en += p; e.lat += p + 1; e.fail = 0; e.retry = 2'(k);
                break;
            end
            e.en += VL; e.lat += VL + 1;
        end
        return e;
    endfunction

    function automatic logic [VL-1:0] rand_vec(input int k);
        logic [VL-1:0] v = '0;
        int c = 0;
        while (c < k) begin
            int i = $urandom_range(VL-1);
            if (!v[i]) begin v[i] = 1'b1; c++; end
        end
        return v;
    endfunction

    task automatic issue(input logic m);
        exp_t e;
        @(negedge clk);
        cur_base = st_cnt;
        e = model(m);
        e.start = cyc + 1; e.en_base = en_cnt; e.st_base = st_cnt;
        sb.push_back(e);
        mode = m; req = 1'b1;
    endtask

    task automatic wait_done(input logic hold);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (!hold) req = 1'b0;
            else mode = ~mode;
            if (done) break;
            if (++n > 4000) begin chk("done_timeout", n, 0); break; end
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_src_req"}, int'(src_req), 0);
        chk({tag, "_sel_start"}, int'(sel_start), 0);
        chk({tag, "_sel_en"}, int'(sel_en), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_sel_number"}, int'(sel_number), 128);
        chk({tag, "_retry_cnt"}, int'(retry_cnt), 0);
    endtask

    task automatic set_vecs(input int k0, input int k1, input int k2, input int k3);
        cur_vecs[0] = rand_vec(k0); cur_vecs[1] = rand_vec(k1);
        cur_vecs[2] = rand_vec(k2); cur_vecs[3] = rand_vec(k3);
        for (int i = 0; i < 4; i++) cur_delay[i] = 0;
    endtask

    initial begin
        resetn = 0; req = 0; mode = 0;
        for (int i = 0; i < 4; i++) begin cur_vecs[i] = '0; cur_delay[i] = 0; end
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        resetn = 1;

        // dense vector, mode 0
        set_vecs(VL, VL, VL, VL);
        issue(0); wait_done(0);

        // exactly 256 ones in the low bits: completes on the last shift
        set_vecs(0, VL, VL, VL);
        for (int i = 0; i < 256; i++) cur_vecs[0][i] = 1'b1;
        issue(1); wait_done(0);

        // short first vector, full second
        set_vecs(100, VL, VL, VL);
        issue(0); wait_done(0);

        // every vector short: retries exhausted, then a clean restart
        set_vecs(10, 10, 10, 10);
        issue(0); wait_done(0);
        set_vecs(VL, VL, VL, VL);
        issue(0); wait_done(0);

        // abort in the second attempt at shift 50
        set_vecs(10, 10, 10, 10);
        issue(1);
        begin
            int n = 0, base = en_cnt;
            @(negedge clk); req = 0;
            while (en_cnt - base < VL + 50 && n < 3000) begin @(posedge clk); n++; end
            if (n >= 3000) chk("reset_reach_timeout", n, 0);
        end
        #2 resetn = 0;
        #1 chk_reset_state("abort");
        sb.delete();
        repeat (5) @(negedge clk);
        resetn = 1;
        repeat (20) @(negedge clk);
        set_vecs(VL, VL, VL, VL);
        issue(0); wait_done(0);

        // req held with mode toggling, 20-cycle source delay
        set_vecs(300, VL, VL, VL);
        cur_delay[0] = 20;
        issue(0); wait_done(1);
        repeat (5) @(negedge clk);
        chk("no_extra_start", int'(busy), 0);

        // randomized requests
        for (int r = 0; r < 8; r++) begin
            logic m = 1'($urandom_range(1));
            set_vecs($urandom_range(VL, 60), $urandom_range(VL, 60),
                     $urandom_range(VL, 60), $urandom_range(VL, 60));
            for (int i = 0; i < 4; i++) cur_delay[i] = $urandom_range(5);
            issue(m); wait_done(r[0]);
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
